// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code decoder with a held-key bitmap over a configurable key table.
// Resolves E0/F0/E1 prefixes and emits press/release pulses and a per-code event record.
module ps2_key_tracker #(
  parameter int                   N_KEYS      = 8,
  parameter logic [9*N_KEYS-1:0]  KEY_CODES   = {9'h01B, 9'h01C, 9'h01D, 9'h029,
                                                 9'h174, 9'h172, 9'h16B, 9'h175},
  parameter bit                   REPEAT_EN   = 1'b0,
  parameter int                   TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              evt_valid,
  output logic [8:0]        evt_code,
  output logic              evt_break,
  output logic              flush
);

  localparam int              CW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    SKIP    = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [2:0]        skip_cnt;
  logic [2:0]        skip_next;
  logic [CW-1:0]     to_cnt;
  logic              expire;

  logic              is_e0;
  logic              is_f0;
  logic              is_e1;
  logic              is_stat;

  logic              ev_make;
  logic              ev_break;
  logic              ev_ext;
  logic              do_flush;
  logic [N_KEYS-1:0] match;

  logic [N_KEYS-1:0] key_state_next;
  logic [N_KEYS-1:0] key_press_next;
  logic [N_KEYS-1:0] key_release_next;
  logic              evt_valid_next;
  logic [8:0]        evt_code_next;
  logic              evt_break_next;
  logic              flush_next;

  assign is_e0   = (rx_data == 8'hE0);
  assign is_f0   = (rx_data == 8'hF0);
  assign is_e1   = (rx_data == 8'hE1);
  assign is_stat = (rx_data == 8'hAA) || (rx_data == 8'hFC) ||
                   (rx_data == 8'h00) || (rx_data == 8'hFF);

  // A byte arriving on the expiry cycle is still decoded in the current state.
  assign expire = (state != IDLE) && (to_cnt == TO_LAST) && !rx_valid;

  // State, skip counter and inter-byte timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      skip_cnt <= 3'd0;
      to_cnt   <= '0;
    end else begin
      state    <= state_next;
      skip_cnt <= skip_next;
      if (rx_valid || (state == IDLE) || expire) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + CW'(1);
      end
    end
  end

  // Prefix sequencing and pause-sequence skipping.
  always_comb begin
    state_next = state;
    skip_next  = skip_cnt;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (is_e0) begin
            state_next = EXT;
          end else if (is_f0) begin
            state_next = BRK;
          end else if (is_e1) begin
            state_next = SKIP;
            skip_next  = SKIP_LEN;
          end else begin
            state_next = IDLE;
          end
        end
        EXT: begin
          if (is_f0) begin
            state_next = EXT_BRK;
          end else if (is_e0) begin
            state_next = EXT;
          end else begin
            state_next = IDLE;
          end
        end
        BRK, EXT_BRK: begin
          if (is_e0) begin
            state_next = EXT;
          end else if (is_f0) begin
            state_next = state;
          end else begin
            state_next = IDLE;
          end
        end
        SKIP: begin
          skip_next = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) begin
            state_next = IDLE;
          end else begin
            state_next = SKIP;
          end
        end
        default: begin
          state_next = IDLE;
          skip_next  = 3'd0;
        end
      endcase
    end else if (expire) begin
      state_next = IDLE;
      skip_next  = 3'd0;
    end else begin
      state_next = state;
    end
  end

  // Classify the current byte into make / break / flush actions.
  always_comb begin
    ev_make  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    do_flush = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (is_e0 || is_f0 || is_e1) begin
            ev_make = 1'b0;
          end else if (is_stat) begin
            do_flush = 1'b1;
          end else begin
            ev_make = 1'b1;
          end
        end
        EXT: begin
          if (!is_e0 && !is_f0) begin
            ev_make = 1'b1;
            ev_ext  = 1'b1;
          end else begin
            ev_make = 1'b0;
          end
        end
        BRK: begin
          if (!is_e0 && !is_f0) begin
            ev_break = 1'b1;
          end else begin
            ev_break = 1'b0;
          end
        end
        EXT_BRK: begin
          if (!is_e0 && !is_f0) begin
            ev_break = 1'b1;
            ev_ext   = 1'b1;
          end else begin
            ev_break = 1'b0;
          end
        end
        default: begin
          ev_make  = 1'b0;
          ev_break = 1'b0;
        end
      endcase
    end else begin
      ev_make = 1'b0;
    end
  end

  // Table lookup: every entry equal to {ext, code} participates.
  always_comb begin
    match = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      match[i] = (KEY_CODES[9*i +: 9] == {ev_ext, rx_data});
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    key_state_next   = key_state;
    key_press_next   = '0;
    key_release_next = '0;
    evt_valid_next   = ev_make || ev_break;
    flush_next       = do_flush;
    evt_code_next    = evt_code;
    evt_break_next   = evt_break;
    if (do_flush) begin
      key_release_next = key_state;
      key_state_next   = '0;
    end else if (ev_make) begin
      evt_code_next  = {ev_ext, rx_data};
      evt_break_next = 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (match[i]) begin
          key_press_next[i] = !key_state[i] || REPEAT_EN;
          key_state_next[i] = 1'b1;
        end else begin
          key_press_next[i] = 1'b0;
        end
      end
    end else if (ev_break) begin
      evt_code_next  = {ev_ext, rx_data};
      evt_break_next = 1'b1;
      for (int i = 0; i < N_KEYS; i++) begin
        if (match[i]) begin
          key_release_next[i] = key_state[i];
          key_state_next[i]   = 1'b0;
        end else begin
          key_release_next[i] = 1'b0;
        end
      end
    end else begin
      key_state_next = key_state;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
      evt_valid   <= 1'b0;
      evt_code    <= 9'h000;
      evt_break   <= 1'b0;
      flush       <= 1'b0;
    end else begin
      key_state   <= key_state_next;
      key_press   <= key_press_next;
      key_release <= key_release_next;
      evt_valid   <= evt_valid_next;
      evt_code    <= evt_code_next;
      evt_break   <= evt_break_next;
      flush       <= flush_next;
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Table-driven scoreboard bench for ps2_key_tracker; a second instance with
// REPEAT_EN=1 shares the stimulus so typematic pulses can be compared.
module tb_ps2_key_tracker;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic [7:0] key_state, key_press, key_release;
  logic       evt_valid, evt_break, flush;
  logic [8:0] evt_code;

  logic [7:0] r_state, r_press, r_release;
  logic       r_valid, r_break, r_flush;
  logic [8:0] r_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] st;
    logic [7:0] pr;
    logic [7:0] prr;
    logic [7:0] rl;
    logic       ev;
    logic [8:0] code;
    logic       brk;
    logic       fl;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  ps2_key_tracker #(.REPEAT_EN(1'b0), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_state(key_state), .key_press(key_press), .key_release(key_release),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_break(evt_break), .flush(flush)
  );

  ps2_key_tracker #(.REPEAT_EN(1'b1), .TIMEOUT_CYC(TO)) dut_rep (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_state(r_state), .key_press(r_press), .key_release(r_release),
    .evt_valid(r_valid), .evt_code(r_code), .evt_break(r_break), .flush(r_flush)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] d, input logic [7:0] st, input logic [7:0] pr,
                              input logic [7:0] prr, input logic [7:0] rl, input logic ev,
                              input logic [8:0] code, input logic brk, input logic fl);
    vec_t v;
    v.data = d; v.st = st; v.pr = pr; v.prr = prr; v.rl = rl;
    v.ev = ev; v.code = code; v.brk = brk; v.fl = fl;
    return v;
  endfunction

  task automatic add(input logic [7:0] d, input logic [7:0] st, input logic [7:0] pr,
                     input logic [7:0] prr, input logic [7:0] rl, input logic ev,
                     input logic [8:0] code, input logic brk, input logic fl);
    vecs.push_back(mk(d, st, pr, prr, rl, ev, code, brk, fl));
  endtask

  task automatic check(input string name, input vec_t e);
    checks++;
    if (key_state !== e.st || key_press !== e.pr || key_release !== e.rl ||
        evt_valid !== e.ev || evt_code !== e.code || evt_break !== e.brk ||
        flush !== e.fl || r_press !== e.prr) begin
      errors++;
      $display("FAIL %s: got st=%h pr=%h rl=%h ev=%b code=%h brk=%b fl=%b prr=%h, want st=%h pr=%h rl=%h ev=%b code=%h brk=%b fl=%b prr=%h",
               name, key_state, key_press, key_release, evt_valid, evt_code, evt_break, flush, r_press,
               e.st, e.pr, e.rl, e.ev, e.code, e.brk, e.fl, e.prr);
    end
  endtask

  // Drive one byte; its expectation is queued and popped once the DUT has clocked it.
  task automatic send(input string name, input vec_t e);
    vec_t x;
    sb.push_back(e);
    rx_data  = e.data;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    x = sb.pop_front();
    check(name, x);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // data  st     pr     prr    rl     ev    code     brk   fl
    add(8'h1D, 8'h20, 8'h20, 8'h20, 8'h00, 1'b1, 9'h01D, 1'b0, 1'b0);
    add(8'hF0, 8'h20, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01D, 1'b0, 1'b0);
    add(8'h1D, 8'h00, 8'h00, 8'h00, 8'h20, 1'b1, 9'h01D, 1'b1, 1'b0);
    add(8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01D, 1'b1, 1'b0);
    add(8'h75, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1, 9'h175, 1'b0, 1'b0);
    add(8'h75, 8'h01, 8'h00, 8'h00, 8'h00, 1'b1, 9'h075, 1'b0, 1'b0);
    add(8'hE0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 9'h075, 1'b0, 1'b0);
    add(8'hF0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 9'h075, 1'b0, 1'b0);
    add(8'h75, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 9'h175, 1'b1, 1'b0);
    add(8'h29, 8'h10, 8'h10, 8'h10, 8'h00, 1'b1, 9'h029, 1'b0, 1'b0);
    add(8'h29, 8'h10, 8'h00, 8'h10, 8'h00, 1'b1, 9'h029, 1'b0, 1'b0);
    add(8'h29, 8'h10, 8'h00, 8'h10, 8'h00, 1'b1, 9'h029, 1'b0, 1'b0);
    add(8'hF0, 8'h10, 8'h00, 8'h00, 8'h00, 1'b0, 9'h029, 1'b0, 1'b0);
    add(8'h29, 8'h00, 8'h00, 8'h00, 8'h10, 1'b1, 9'h029, 1'b1, 1'b0);
    add(8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h029, 1'b1, 1'b0);
    add(8'h75, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1, 9'h175, 1'b0, 1'b0);
    add(8'h1D, 8'h21, 8'h20, 8'h20, 8'h00, 1'b1, 9'h01D, 1'b0, 1'b0);
    add(8'hAA, 8'h00, 8'h00, 8'h00, 8'h21, 1'b0, 9'h01D, 1'b0, 1'b1);
    add(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01D, 1'b0, 1'b0);
    add(8'h1B, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 9'h01B, 1'b1, 1'b0);
    // pause sequence: E1 plus seven skipped bytes
    add(8'hE1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01B, 1'b1, 1'b0);
    add(8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01B, 1'b1, 1'b0);
    add(8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01B, 1'b1, 1'b0);
    add(8'hE1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01B, 1'b1, 1'b0);
    add(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01B, 1'b1, 1'b0);
    add(8'h14, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01B, 1'b1, 1'b0);
    add(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01B, 1'b1, 1'b0);
    add(8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01B, 1'b1, 1'b0);
    add(8'h1B, 8'h80, 8'h80, 8'h80, 8'h00, 1'b1, 9'h01B, 1'b0, 1'b0);
    // E0 inside EXT_BRK restarts as EXT
    add(8'hE0, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01B, 1'b0, 1'b0);
    add(8'hF0, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01B, 1'b0, 1'b0);
    add(8'hE0, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01B, 1'b0, 1'b0);
    add(8'h75, 8'h81, 8'h01, 8'h01, 8'h00, 1'b1, 9'h175, 1'b0, 1'b0);
    // E0 inside BRK restarts as EXT
    add(8'hF0, 8'h81, 8'h00, 8'h00, 8'h00, 1'b0, 9'h175, 1'b0, 1'b0);
    add(8'hE0, 8'h81, 8'h00, 8'h00, 8'h00, 1'b0, 9'h175, 1'b0, 1'b0);
    add(8'hF0, 8'h81, 8'h00, 8'h00, 8'h00, 1'b0, 9'h175, 1'b0, 1'b0);
    add(8'h75, 8'h80, 8'h00, 8'h00, 8'h01, 1'b1, 9'h175, 1'b1, 1'b0);
    add(8'hE0, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 9'h175, 1'b1, 1'b0);
    add(8'hE0, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 9'h175, 1'b1, 1'b0);
    add(8'h75, 8'h81, 8'h01, 8'h01, 8'h00, 1'b1, 9'h175, 1'b0, 1'b0);
    add(8'hF0, 8'h81, 8'h00, 8'h00, 8'h00, 1'b0, 9'h175, 1'b0, 1'b0);
    add(8'hF0, 8'h81, 8'h00, 8'h00, 8'h00, 1'b0, 9'h175, 1'b0, 1'b0);
    add(8'h1B, 8'h01, 8'h00, 8'h00, 8'h80, 1'b1, 9'h01B, 1'b1, 1'b0);
    add(8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 9'h01B, 1'b1, 1'b1);
    add(8'h1C, 8'h40, 8'h40, 8'h40, 8'h00, 1'b1, 9'h01C, 1'b0, 1'b0);
    add(8'hFF, 8'h00, 8'h00, 8'h00, 8'h40, 1'b0, 9'h01C, 1'b0, 1'b1);
    add(8'hFC, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01C, 1'b0, 1'b1);
    add(8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01C, 1'b0, 1'b0);
    add(8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 9'h11C, 1'b0, 1'b0);

    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset", mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0));
    reset = 1'b0;
    idle(2);

    // back-to-back table at full strobe rate
    for (int i = 0; i < vecs.size(); i++) begin
      send($sformatf("vec%0d", i), vecs[i]);
    end
    idle(3);

    // timeout: E0 then TO idle cycles drops the prefix
    send("to_e0", mk(8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h11C, 1'b0, 1'b0));
    idle(TO);
    send("to_after", mk(8'h1C, 8'h40, 8'h40, 8'h40, 8'h00, 1'b1, 9'h01C, 1'b0, 1'b0));
    idle(2);
    // byte on the exact expiry cycle wins and is decoded as extended
    send("to_e0b", mk(8'hE0, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01C, 1'b0, 1'b0));
    idle(TO - 1);
    send("to_edge", mk(8'h1C, 8'h40, 8'h00, 8'h00, 8'h00, 1'b1, 9'h11C, 1'b0, 1'b0));
    send("to_f0", mk(8'hF0, 8'h40, 8'h00, 8'h00, 8'h00, 1'b0, 9'h11C, 1'b0, 1'b0));
    send("to_brk", mk(8'h1C, 8'h00, 8'h00, 8'h00, 8'h40, 1'b1, 9'h01C, 1'b1, 1'b0));
    idle(2);

    // reset after F0: no release, next 1B is a make
    send("rs_mk", mk(8'h1B, 8'h80, 8'h80, 8'h80, 8'h00, 1'b1, 9'h01B, 1'b0, 1'b0));
    send("rs_f0", mk(8'hF0, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, 9'h01B, 1'b0, 1'b0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rs_clear", mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0));
    reset = 1'b0;
    send("rs_after", mk(8'h1B, 8'h80, 8'h80, 8'h80, 8'h00, 1'b1, 9'h01B, 1'b0, 1'b0));
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
